datapath_sequencer: RTL and testbench

Hardwired control sequencer for the single-bus CPU datapath (general register file R0–R15, PC, IR, MAR, MDR, Y, Z, HI, LO). It steps through fetch and execute T-states and drives every register enable, bus-source select and ALU opcode, so that each register's load enable is asserted for exactly the cycles a transfer requires. It sits between the instruction register and the datapath control inputs, and stalls on the memory read handshake.

---
 rtl/datapath_sequencer.sv | 163 ++++++++++++++++
 tb/tb_datapath_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: hardwired T-state control for a single-bus CPU.
// Strobes decode from state and ir; PCin alone also watches mem_ready.
module datapath_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIin,
  output logic        LOin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic [4:0]  alu_op,
  output logic        instr_done,
  output logic        illegal,
  output logic        halted,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    T0     = 4'd1,
    T1     = 4'd2,
    T2     = 4'd3,
    T3     = 4'd4,
    T4     = 4'd5,
    T5     = 4'd6,
    T6     = 4'd7,
    HALTED = 4'd8
  } state_t;

  state_t     cur;
  logic [4:0] op;
  logic       is_bin;
  logic       is_wide;
  logic       is_un;
  logic       is_nop;
  logic       is_halt;
  logic       unused_ir;

  assign op        = ir[31:27];
  assign unused_ir = ^ir[26:0];
  assign state     = cur;

  assign is_bin  = (op <= 5'd8);
  assign is_wide = (op == 5'd15) | (op == 5'd16);
  assign is_un   = (op == 5'd17) | (op == 5'd18);
  assign is_nop  = (op == 5'd26);
  assign is_halt = (op == 5'd27);

  always_ff @(posedge clock) begin
    if (clear) begin
      cur <= IDLE;
    end else begin
      unique case (cur)
        IDLE:   if (run) cur <= T0;
        T0:     cur <= T1;
        T1:     if (mem_ready) cur <= T2;
        T2:     cur <= T3;
        T3: begin
          if (is_halt)
            cur <= HALTED;
          else if (is_bin | is_wide | is_un)
            cur <= T4;
          else
            cur <= run ? T0 : IDLE;
        end
        T4:     cur <= is_un ? (run ? T0 : IDLE) : T5;
        T5:     cur <= is_wide ? T6 : (run ? T0 : IDLE);
        T6:     cur <= run ? T0 : IDLE;
        HALTED: cur <= HALTED;
        default: cur <= IDLE;
      endcase
    end
  end

  always_comb begin
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0;
    MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
    Read = 1'b0; IRin = 1'b0; Yin = 1'b0;
    Zin = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
    HIin = 1'b0; LOin = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    Rin = 1'b0; Rout = 1'b0;
    alu_op = 5'd0;
    instr_done = 1'b0; illegal = 1'b0;
    halted = 1'b0;
    unique case (cur)
      T0: begin
        PCout = 1'b1; MARin = 1'b1;
        IncPC = 1'b1; Zin = 1'b1;
      end
      T1: begin
        Zlowout = 1'b1; Read = 1'b1; MDRin = 1'b1;
        // PC loads only on the cycle T1 is left
        PCin = mem_ready;
      end
      T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      T3: begin
        unique case (1'b1)
          is_bin:  begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          is_wide: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          is_un: begin
            Grb = 1'b1; Rout = 1'b1;
            Zin = 1'b1; alu_op = op;
          end
          is_halt: instr_done = 1'b1;
          default: begin
            instr_done = 1'b1;
            illegal    = ~is_nop;
          end
        endcase
      end
      T4: begin
        unique case (1'b1)
          is_un: begin
            Zlowout = 1'b1; Gra = 1'b1;
            Rin = 1'b1; instr_done = 1'b1;
          end
          is_wide: begin
            Grb = 1'b1; Rout = 1'b1;
            Zin = 1'b1; alu_op = op;
          end
          default: begin
            Grc = 1'b1; Rout = 1'b1;
            Zin = 1'b1; alu_op = op;
          end
        endcase
      end
      T5: begin
        Zlowout = 1'b1;
        if (is_wide) begin
          LOin = 1'b1;
        end else begin
          Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1;
        end
      end
      T6: begin
        Zhighout = 1'b1; HIin = 1'b1; instr_done = 1'b1;
      end
      HALTED: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: random instruction streams vs a per-class
// cycle-table model, with stalls, run drops and mid-instruction clears.
module tb_datapath_sequencer;

  logic clock = 1'b0;
  logic clear, run, mem_ready;
  logic [31:0] ir;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin;
  logic Yin, Zin, Zhighout, Zlowout, HIin, LOin;
  logic Gra, Grb, Grc, Rin, Rout;
  logic [4:0] alu_op;
  logic instr_done, illegal, halted;
  logic [3:0] state;

  always #5 clock = ~clock;

  datapath_sequencer dut (
    .clock(clock), .clear(clear), .run(run),
    .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .Read(Read), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Zhighout(Zhighout), .Zlowout(Zlowout),
    .HIin(HIin), .LOin(LOin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .alu_op(alu_op),
    .instr_done(instr_done), .illegal(illegal),
    .halted(halted), .state(state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic pco, pci, inc, mar, mdri, mdro, rd, iri;
    logic yi, zi, zho, zlo, hi, lo;
    logic gra, grb, grc, rin, rout;
    logic done, ill, hlt;
    logic [4:0] alu;
  } obs_t;

  typedef struct {
    obs_t        e;
    logic [31:0] ir;
    bit          mr;
    bit          rn;
    bit          clr;
  } step_t;

  obs_t obs;
  assign obs = {state, PCout, PCin, IncPC, MARin, MDRin,
                MDRout, Read, IRin, Yin, Zin, Zhighout,
                Zlowout, HIin, LOin, Gra, Grb, Grc, Rin,
                Rout, instr_done, illegal, halted, alu_op};

  step_t       plan[$];
  logic [31:0] cur_ir;
  int          ab_st;
  bit          ab_hit;
  bit          idle_now;
  int          n_chk;
  int          n_pass;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t got=%h exp=%h",
                  tag, $time, got, exp);
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic add(input obs_t e, input bit mr, input bit rn);
    step_t s;
    if (ab_hit) return;
    s.e = e; s.ir = cur_ir;
    s.mr = mr; s.rn = rn; s.clr = 1'b0;
    if (int'(e.st) == ab_st) begin
      s.clr  = 1'b1;
      ab_hit = 1'b1;
    end
    plan.push_back(s);
  endtask

  task automatic gen(input logic [4:0] op, input int stalls,
                     input bit run_end, input int abort_st,
                     input int halt_cyc);
    obs_t e;
    bit bin, wide, un, hlt;
    bin  = (op <= 5'd8);
    wide = (op == 5'd15) || (op == 5'd16);
    un   = (op == 5'd17) || (op == 5'd18);
    hlt  = (op == 5'd27);
    cur_ir = {op, 27'($urandom)};
    ab_st  = abort_st;
    ab_hit = 1'b0;
    if (idle_now) begin
      repeat ($urandom_range(0, 2)) begin
        e = '0; add(e, rb(), 1'b0);
      end
      e = '0; add(e, rb(), 1'b1);
    end
    e = '0; e.st = 4'd1;
    e.pco = 1; e.mar = 1; e.inc = 1; e.zi = 1;
    add(e, rb(), rb());
    e = '0; e.st = 4'd2;
    e.zlo = 1; e.rd = 1; e.mdri = 1;
    for (int i = 0; i < stalls; i++) add(e, 1'b0, rb());
    e.pci = 1;
    add(e, 1'b1, rb());
    e = '0; e.st = 4'd3; e.mdro = 1; e.iri = 1;
    add(e, rb(), rb());
    e = '0; e.st = 4'd4;
    if (bin) begin
      e.grb = 1; e.rout = 1; e.yi = 1;
      add(e, rb(), rb());
      e = '0; e.st = 4'd5;
      e.grc = 1; e.rout = 1; e.zi = 1; e.alu = op;
      add(e, rb(), rb());
      e = '0; e.st = 4'd6;
      e.zlo = 1; e.gra = 1; e.rin = 1; e.done = 1;
      add(e, rb(), run_end);
    end else if (wide) begin
      e.gra = 1; e.rout = 1; e.yi = 1;
      add(e, rb(), rb());
      e = '0; e.st = 4'd5;
      e.grb = 1; e.rout = 1; e.zi = 1; e.alu = op;
      add(e, rb(), rb());
      e = '0; e.st = 4'd6; e.zlo = 1; e.lo = 1;
      add(e, rb(), rb());
      e = '0; e.st = 4'd7;
      e.zho = 1; e.hi = 1; e.done = 1;
      add(e, rb(), run_end);
    end else if (un) begin
      e.grb = 1; e.rout = 1; e.zi = 1; e.alu = op;
      add(e, rb(), rb());
      e = '0; e.st = 4'd5;
      e.zlo = 1; e.gra = 1; e.rin = 1; e.done = 1;
      add(e, rb(), run_end);
    end else if (hlt) begin
      e.done = 1;
      add(e, rb(), rb());
      e = '0; e.st = 4'd8; e.hlt = 1;
      for (int i = 0; i < halt_cyc; i++) add(e, rb(), rb());
      if (!ab_hit) plan[$].clr = 1'b1;
    end else begin
      e.done = 1;
      e.ill  = (op != 5'd26);
      add(e, rb(), run_end);
    end
    idle_now = ab_hit || hlt || !run_end;
  endtask

  task automatic run_plan();
    step_t s;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      @(negedge clock);
      clear = s.clr; run = s.rn;
      mem_ready = s.mr; ir = s.ir;
      #1;
      check($sformatf("st%0d", s.e.st), {1'b0, obs}, {1'b0, s.e});
      check("bus1h",
            32'($countones({PCout, Zlowout, Zhighout,
                            MDRout, Rout}) <= 1),
            32'd1);
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    clear = 1'b1; run = 1'b0;
    mem_ready = 1'b0; ir = '0;
    idle_now = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    check("reset", {1'b0, obs}, 32'd0);

    gen(5'd0,  0, 1'b1, -1, 0);
    gen(5'd0,  3, 1'b1, -1, 0);
    gen(5'd15, 0, 1'b1, -1, 0);
    gen(5'd31, 0, 1'b0, -1, 0);
    gen(5'd1,  0, 1'b1,  5, 0);
    gen(5'd27, 0, 1'b1, -1, 22);
    gen(5'd17, 1, 1'b1, -1, 0);
    gen(5'd26, 0, 1'b1, -1, 0);
    run_plan();

    for (int n = 0; n < 300; n++) begin
      gen(5'($urandom_range(0, 31)),
          ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0,
          $urandom_range(0, 3) != 0,
          ($urandom_range(0, 9) == 0) ? $urandom_range(1, 7) : -1,
          $urandom_range(1, 5));
      run_plan();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
